quiz_event_gen: RTL and testbench
=================================

# quiz_event_gen

Event generator feeding the quiz-responder control FSM: it turns host, contestant and judge buttons into the single-cycle event pulses the controller consumes (starttimer, stoptime, endtime, startgame, endgame, yes, no). It reads back the controller's one-hot show_* state so that each event is emitted only when it is legal and only once per state. It also owns the answer countdown, first-press arbitration and per-player scores. Set-mode events (startset/endset) are out of scope.

## Interface
- N_PLAYERS, 4, contestant count, 2..8; ID_W = $clog2(N_PLAYERS).
- TICK_DIV, 100_000_000, clk cycles per countdown second, ≥2.
- ANSWER_SECS, 10, countdown start value, 1..2^SEC_W-1.
- SEC_W, 4, width of seconds_left.
- SCORE_W, 4, per-player score width.
- WIN_SCORE, 9, score that ends the game, ≤2^SCORE_W-1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- show_time, show_who, show_set, show_score, show_ready  in  1 each  controller state, one-hot.
- btn_start  in  1  host start, debounced level, asynchronous.
- btn_player  in  N_PLAYERS  contestant buttons, debounced levels, asynchronous.
- btn_yes, btn_no  in  1 each  judge verdict, debounced levels, asynchronous.
- starttimer, stoptime, endtime, startgame, endgame, yes, no  out  1 each  registered single-cycle event pulses.
- winner  out  ID_W  latched first-press player index.
- winner_valid  out  1  winner holds a valid value.
- seconds_left  out  SEC_W  countdown value.
- scores  out  N_PLAYERS*SCORE_W  player i occupies bits [i*SCORE_W +: SCORE_W].
- game_won  out  1  some score has reached WIN_SCORE.

## Operation
- Input conditioning: every button passes through a 2-FF synchronizer. A third register gives rising-edge detect (s2 & ~s3). Only edges act; held levels never repeat.
- Show vector not one-hot: no pulses are emitted and no state changes, except the tick counter.
- Once guard: a sent flag sets on any pulse and clears when the registered show_* vector differs from its previous value. While the flag is set, no new pulses are emitted.
- READY: a btn_start edge with game_won=0 emits starttimer. It also loads seconds_left=ANSWER_SECS, clears tick_cnt, clears winner_valid and clears the freeze flag. With game_won=1, btn_start is ignored and endgame pulses once.
- TIME: tick_cnt counts 0..TICK_DIV-1 while not frozen. On wrap it decrements seconds_left, with no decrement below 0.
  - Any player edge: the lowest index among simultaneous edges wins. The block latches winner, sets winner_valid, freezes the countdown and emits stoptime.
  - seconds_left==0 with no player edge in that cycle: emit endtime.
  - Press and expiry in the same cycle: the press wins (stoptime only).
  - Player edges outside TIME are ignored.
- WHO:
  - btn_yes edge alone: emit yes and startgame together. scores[winner] increments, saturating at 2^SCORE_W-1. If the new value is ≥ WIN_SCORE, game_won sets.
  - btn_no edge alone: emit no and startgame. Scores are unchanged.
  - Both edges in the same cycle: ignore both.
- SCORE, SET: no pulses are emitted; scores are held. game_won stays set until rst.
- Reset: all pulses 0, winner 0, winner_valid 0, seconds_left 0, tick_cnt 0, scores all 0, game_won 0, sent 0, synchronizers 0. Reset mid-countdown aborts immediately.

## Timing
- A raw button first sampled high at clk edge k produces its pulse high from edge k+2 to k+3, provided the state and guard permit it. Button-to-pulse latency is therefore 2 cycles after the synchronizer capture.
- All outputs are registered; there is no combinational path from any input to any output.
- The seconds_left load appears in the same cycle as starttimer. The score update and game_won appear in the same cycle as yes.
- The first decrement occurs TICK_DIV cycles after starttimer, counted while show_time is asserted. Subsequent decrements are TICK_DIV apart.
- endtime fires in the first cycle in which seconds_left==0, show_time=1 and sent=0.
- The controller is expected to change state the cycle after a pulse. The guard covers the one-cycle lag.

## Test plan
- Reset, then show_ready=1 and btn_start raised at edge k -> starttimer high exactly at edge k+2 for one cycle, seconds_left=10, all other outputs 0.
- TICK_DIV=4, ANSWER_SECS=3, show_time held, no presses -> seconds_left steps 3,2,1,0 at 4-cycle spacing, then exactly one endtime pulse, with no repeat while show_time remains high.
- In TIME, btn_player=4'b0110 rising in one cycle -> winner=1, winner_valid=1, one stoptime pulse, seconds_left frozen. A later btn_player[0] edge changes nothing.
- show_who with winner=2: btn_yes -> yes+startgame in the same cycle, scores[2] 0->1. btn_no -> no+startgame, scores unchanged. btn_yes and btn_no together -> no pulses.
- WIN_SCORE=2: second yes for player 0 -> score 2, game_won=1. Then show_ready with btn_start -> no starttimer, exactly one endgame pulse.
- Assert rst at seconds_left=5 with winner_valid=1 -> every output returns to its reset value immediately, and no pulse occurs until new stimulus.

Source files
------------

// File: rtl/quiz_event_gen_if.sv
// Bundle between the event generator (master) and the controller/host side (slave):
// controller state and raw buttons in, event pulses and game status out.
interface quiz_event_gen_if #(
    parameter int N_PLAYERS = 4,
    parameter int SEC_W     = 4,
    parameter int SCORE_W   = 4
);
    localparam int ID_W = $clog2(N_PLAYERS);

    logic                         show_time;
    logic                         show_who;
    logic                         show_set;
    logic                         show_score;
    logic                         show_ready;
    logic                         btn_start;
    logic [N_PLAYERS-1:0]         btn_player;
    logic                         btn_yes;
    logic                         btn_no;
    logic                         starttimer;
    logic                         stoptime;
    logic                         endtime;
    logic                         startgame;
    logic                         endgame;
    logic                         yes;
    logic                         no;
    logic [ID_W-1:0]              winner;
    logic                         winner_valid;
    logic [SEC_W-1:0]             seconds_left;
    logic [N_PLAYERS*SCORE_W-1:0] scores;
    logic                         game_won;

    modport master (
        input  show_time, show_who, show_set, show_score, show_ready,
        input  btn_start, btn_player, btn_yes, btn_no,
        output starttimer, stoptime, endtime, startgame, endgame, yes, no,
        output winner, winner_valid, seconds_left, scores, game_won
    );

    modport slave (
        output show_time, show_who, show_set, show_score, show_ready,
        output btn_start, btn_player, btn_yes, btn_no,
        input  starttimer, stoptime, endtime, startgame, endgame, yes, no,
        input  winner, winner_valid, seconds_left, scores, game_won
    );
endinterface

// File: rtl/quiz_event_gen.sv
// Quiz event generator: synchronizes buttons, arbitrates first press, runs the answer
// countdown and scores, and emits one registered pulse per legal event per controller state.
module quiz_event_gen #(
    parameter int N_PLAYERS   = 4,
    parameter int TICK_DIV    = 100_000_000,
    parameter int ANSWER_SECS = 10,
    parameter int SEC_W       = 4,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9
) (
    input logic              clk,
    input logic              rst,
    quiz_event_gen_if.master bus
);
    localparam int ID_W   = $clog2(N_PLAYERS);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BTN_W  = N_PLAYERS + 3;

    logic [BTN_W-1:0]     btn_raw, sync1, sync2, sync3, btn_edge;
    logic                 start_e, yes_e, no_e, any_press;
    logic [N_PLAYERS-1:0] player_e;
    logic [4:0]           show_q, show_prev;
    logic                 one_hot, armed, sent, frozen;
    logic [TICK_W-1:0]    tick_cnt;
    logic                 tick_wrap;
    logic [ID_W-1:0]      first_id, winner_q;
    logic                 winner_valid_q, game_won_q;
    logic [SEC_W-1:0]     seconds_q;
    logic [SCORE_W-1:0]   score_r [N_PLAYERS];
    logic [SCORE_W-1:0]   cur_score, new_score;
    logic do_start, do_endgame, do_stop, do_endtime, do_yes, do_no, any_pulse;
    logic starttimer_q, stoptime_q, endtime_q, startgame_q, endgame_q, yes_q, no_q;

    assign btn_raw  = {bus.btn_no, bus.btn_yes, bus.btn_player, bus.btn_start};
    assign btn_edge = sync2 & ~sync3;
    assign start_e  = btn_edge[0];
    assign player_e = btn_edge[N_PLAYERS:1];
    assign yes_e    = btn_edge[N_PLAYERS+1];
    assign no_e     = btn_edge[N_PLAYERS+2];
    assign any_press = |player_e;

    // show_q = {ready, score, set, who, time}
    assign one_hot   = (show_q != '0) && ((show_q & (show_q - 5'd1)) == '0);
    assign armed     = one_hot && !sent;
    assign tick_wrap = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_comb begin
        first_id = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (player_e[i]) first_id = ID_W'(i);
        end
    end

    // A press beats expiry in the same cycle; yes and no together cancel each other.
    assign do_start   = armed && show_q[4] && start_e && !game_won_q;
    assign do_endgame = armed && show_q[4] && game_won_q;
    assign do_stop    = armed && show_q[0] && any_press;
    assign do_endtime = armed && show_q[0] && !any_press && (seconds_q == '0);
    assign do_yes     = armed && show_q[1] && yes_e && !no_e;
    assign do_no      = armed && show_q[1] && no_e && !yes_e;
    assign any_pulse  = do_start | do_endgame | do_stop | do_endtime | do_yes | do_no;

    assign cur_score = score_r[winner_q];
    assign new_score = (cur_score == '1) ? cur_score : cur_score + SCORE_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1          <= '0;
            sync2          <= '0;
            sync3          <= '0;
            show_q         <= '0;
            show_prev      <= '0;
            sent           <= 1'b0;
            frozen         <= 1'b0;
            tick_cnt       <= '0;
            seconds_q      <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            game_won_q     <= 1'b0;
            starttimer_q   <= 1'b0;
            stoptime_q     <= 1'b0;
            endtime_q      <= 1'b0;
            startgame_q    <= 1'b0;
            endgame_q      <= 1'b0;
            yes_q          <= 1'b0;
            no_q           <= 1'b0;
            for (int i = 0; i < N_PLAYERS; i++) score_r[i] <= '0;
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            sync3     <= sync2;
            show_q    <= {bus.show_ready, bus.show_score, bus.show_set, bus.show_who, bus.show_time};
            show_prev <= show_q;

            starttimer_q <= do_start;
            stoptime_q   <= do_stop;
            endtime_q    <= do_endtime;
            startgame_q  <= do_yes | do_no;
            endgame_q    <= do_endgame;
            yes_q        <= do_yes;
            no_q         <= do_no;

            // Guard stays set until the controller is seen to move to another state.
            if (any_pulse) sent <= 1'b1;
            else if (show_q != show_prev) sent <= 1'b0;

            if (do_start) tick_cnt <= '0;
            else if (show_q[0] && !frozen) tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);

            if (do_start) begin
                seconds_q      <= SEC_W'(ANSWER_SECS);
                winner_valid_q <= 1'b0;
                frozen         <= 1'b0;
            end else if (do_stop) begin
                winner_q       <= first_id;
                winner_valid_q <= 1'b1;
                frozen         <= 1'b1;
            end else if (one_hot && show_q[0] && !frozen && tick_wrap && seconds_q != '0) begin
                seconds_q <= seconds_q - SEC_W'(1);
            end

            if (do_yes) begin
                score_r[winner_q] <= new_score;
                if (new_score >= SCORE_W'(WIN_SCORE)) game_won_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.scores = '0;
        for (int i = 0; i < N_PLAYERS; i++) bus.scores[i*SCORE_W +: SCORE_W] = score_r[i];
    end

    assign bus.starttimer   = starttimer_q;
    assign bus.stoptime     = stoptime_q;
    assign bus.endtime      = endtime_q;
    assign bus.startgame    = startgame_q;
    assign bus.endgame      = endgame_q;
    assign bus.yes          = yes_q;
    assign bus.no           = no_q;
    assign bus.winner       = winner_q;
    assign bus.winner_valid = winner_valid_q;
    assign bus.seconds_left = seconds_q;
    assign bus.game_won     = game_won_q;
endmodule

// File: tb/tb_quiz_event_gen.sv
// Directed bench for quiz_event_gen: every pulse is matched against a queue of expected
// event records; directed checks cover timing, countdown, freeze and reset.
module tb_quiz_event_gen;
    localparam int W = 31;
    localparam logic [6:0] P_START = 7'b1000000;
    localparam logic [6:0] P_STOP  = 7'b0100000;
    localparam logic [6:0] P_END   = 7'b0010000;
    localparam logic [6:0] P_SG    = 7'b0001000;
    localparam logic [6:0] P_EG    = 7'b0000100;
    localparam logic [6:0] P_YES   = 7'b0000010;
    localparam logic [6:0] P_NO    = 7'b0000001;
    localparam logic [4:0] S_TIME  = 5'b00001;
    localparam logic [4:0] S_WHO   = 5'b00010;
    localparam logic [4:0] S_SCORE = 5'b01000;
    localparam logic [4:0] S_READY = 5'b10000;

    logic clk, rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_rec;

    quiz_event_gen_if #(.N_PLAYERS(4), .SEC_W(4), .SCORE_W(4)) bus ();

    quiz_event_gen #(
        .N_PLAYERS(4), .TICK_DIV(4), .ANSWER_SECS(5),
        .SEC_W(4), .SCORE_W(4), .WIN_SCORE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] rec(input logic [6:0] p, input logic [3:0] s, input logic wv,
                                         input logic [1:0] w, input logic gw, input logic [15:0] sc);
        return {p, s, wv, w, gw, sc};
    endfunction

    function automatic logic [6:0] obs_pulses();
        return {bus.starttimer, bus.stoptime, bus.endtime, bus.startgame, bus.endgame, bus.yes, bus.no};
    endfunction

    function automatic logic [W-1:0] obs_rec();
        return {obs_pulses(), bus.seconds_left, bus.winner_valid, bus.winner, bus.game_won, bus.scores};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every pulse cycle pops one expected record
    always @(negedge clk) begin
        if (!rst && obs_pulses() != 7'd0) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_pulse observed=%b expected=none", obs_pulses());
            end
            if (exp_q.size() != 0) begin
                exp_rec = exp_q.pop_front();
                total++;
                assert (obs_rec() === exp_rec) else begin
                    bad++;
                    $error("FAIL event_record observed=%h expected=%h", obs_rec(), exp_rec);
                end
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_show(input logic [4:0] v);
        {bus.show_ready, bus.show_score, bus.show_set, bus.show_who, bus.show_time} = v;
    endtask

    task automatic do_start(input logic [1:0] w, input logic [15:0] sc);
        set_show(S_READY);
        tick(4);
        exp_q.push_back(rec(P_START, 4'd5, 1'b0, w, 1'b0, sc));
        bus.btn_start = 1'b1;
        tick(4);
        bus.btn_start = 1'b0;
    endtask

    task automatic do_press(input logic [3:0] pl, input logic [1:0] w, input logic [15:0] sc);
        exp_q.push_back(rec(P_STOP, 4'd5, 1'b1, w, 1'b0, sc));
        set_show(S_TIME);
        bus.btn_player = pl;
        tick(4);
        bus.btn_player = '0;
        tick(1);
    endtask

    task automatic do_verdict(input logic y, input logic n, input logic [6:0] p, input bit expect_pulse,
                              input logic [1:0] w, input logic gw, input logic [15:0] sc);
        set_show(S_WHO);
        tick(4);
        if (expect_pulse) exp_q.push_back(rec(p, 4'd5, 1'b1, w, gw, sc));
        bus.btn_yes = y;
        bus.btn_no  = n;
        tick(4);
        bus.btn_yes = 1'b0;
        bus.btn_no  = 1'b0;
        tick(2);
        set_show(S_SCORE);
        tick(3);
    endtask

    int prev, last_cyc, budget;

    initial begin
        rst = 1'b1;
        set_show(5'b0);
        bus.btn_start  = 1'b0;
        bus.btn_player = '0;
        bus.btn_yes    = 1'b0;
        bus.btn_no     = 1'b0;
        tick(3);
        check("rst_pulses", obs_pulses(), 0);
        check("rst_seconds", bus.seconds_left, 0);
        check("rst_winner", bus.winner, 0);
        check("rst_winner_valid", bus.winner_valid, 0);
        check("rst_scores", bus.scores, 0);
        check("rst_game_won", bus.game_won, 0);
        rst = 1'b0;

        // start pulse timing: raised before edge k, pulse at k+2 only
        set_show(S_READY);
        tick(4);
        exp_q.push_back(rec(P_START, 4'd5, 1'b0, 2'd0, 1'b0, 16'h0000));
        bus.btn_start = 1'b1;
        tick(1); check("start_at_k", bus.starttimer, 0);
        tick(1); check("start_at_k1", bus.starttimer, 0);
        tick(1); check("start_at_k2", bus.starttimer, 1);
        check("start_load", bus.seconds_left, 5);
        tick(1); check("start_at_k3", bus.starttimer, 0);
        bus.btn_start = 1'b0;

        // countdown to zero, then exactly one endtime
        exp_q.push_back(rec(P_END, 4'd0, 1'b0, 2'd0, 1'b0, 16'h0000));
        set_show(S_TIME);
        prev = 5;
        last_cyc = cyc;
        for (int s = 0; s < 5; s++) begin
            budget = 0;
            while (int'(bus.seconds_left) == prev && budget < 12) begin
                @(negedge clk);
                budget++;
            end
            check("countdown_value", bus.seconds_left, prev - 1);
            if (s > 0) check("countdown_gap", cyc - last_cyc, 4);
            last_cyc = cyc;
            prev--;
        end
        tick(20);
        check("endtime_once", exp_q.size(), 0);
        check("floor_zero", bus.seconds_left, 0);

        // first-press arbitration and freeze
        do_start(2'd0, 16'h0000);
        do_press(4'b0110, 2'd1, 16'h0000);
        tick(20);
        check("press_winner", bus.winner, 1);
        check("press_valid", bus.winner_valid, 1);
        check("frozen_seconds", bus.seconds_left, 5);
        bus.btn_player = 4'b0001;
        tick(6);
        bus.btn_player = '0;
        tick(2);
        check("late_press_winner", bus.winner, 1);
        check("late_press_seconds", bus.seconds_left, 5);
        check("press_queue", exp_q.size(), 0);

        // asynchronous reset mid-round
        set_show(S_READY);
        rst = 1'b1;
        #1;
        check("arst_pulses", obs_pulses(), 0);
        check("arst_seconds", bus.seconds_left, 0);
        check("arst_winner", bus.winner, 0);
        check("arst_valid", bus.winner_valid, 0);
        tick(2);
        rst = 1'b0;
        tick(10);
        check("post_rst_quiet", exp_q.size(), 0);
        check("post_rst_seconds", bus.seconds_left, 0);

        // verdicts with winner 2
        do_start(2'd0, 16'h0000);
        do_press(4'b0100, 2'd2, 16'h0000);
        do_verdict(1'b1, 1'b0, P_YES | P_SG, 1'b1, 2'd2, 1'b0, 16'h0100);
        do_verdict(1'b0, 1'b1, P_NO | P_SG, 1'b1, 2'd2, 1'b0, 16'h0100);
        do_verdict(1'b1, 1'b1, 7'd0, 1'b0, 2'd2, 1'b0, 16'h0100);
        bus.btn_yes = 1'b1;
        tick(5);
        bus.btn_yes = 1'b0;
        tick(2);
        check("verdict_scores", bus.scores, 16'h0100);
        check("verdict_queue", exp_q.size(), 0);

        // player 0 reaches WIN_SCORE
        do_start(2'd2, 16'h0100);
        do_press(4'b0001, 2'd0, 16'h0100);
        do_verdict(1'b1, 1'b0, P_YES | P_SG, 1'b1, 2'd0, 1'b0, 16'h0101);
        check("not_won_yet", bus.game_won, 0);
        do_start(2'd0, 16'h0101);
        do_press(4'b0001, 2'd0, 16'h0101);
        do_verdict(1'b1, 1'b0, P_YES | P_SG, 1'b1, 2'd0, 1'b1, 16'h0102);
        check("game_won", bus.game_won, 1);

        // game over: start ignored, one endgame
        exp_q.push_back(rec(P_EG, 4'd5, 1'b1, 2'd0, 1'b1, 16'h0102));
        set_show(S_READY);
        tick(6);
        bus.btn_start = 1'b1;
        tick(4);
        bus.btn_start = 1'b0;
        tick(10);
        check("endgame_queue", exp_q.size(), 0);
        check("final_scores", bus.scores, 16'h0102);
        check("final_won", bus.game_won, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
